// File: rtl/ysyx_23060236_bru_pkg.sv
// Shared widths, FSM state encoding and 2-bit confidence counter constants
// for the branch resolution unit.
package ysyx_23060236_bru_pkg;

    localparam int BRU_ADDR_LEN = 32;
    localparam int BRU_DATA_LEN = 32;

    typedef enum logic {
        BRU_IDLE     = 1'b0,
        BRU_REDIRECT = 1'b1
    } bru_state_e;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'd0;
    localparam cnt_t CNT_WNT = 2'd1;
    localparam cnt_t CNT_WT  = 2'd2;
    localparam cnt_t CNT_ST  = 2'd3;

    // Jumps pin the counter to strongly-taken; branches move one step, saturating.
    function automatic cnt_t cnt_next(input cnt_t cur, input logic is_jmp, input logic taken);
        cnt_t nxt;
        nxt = cur;
        if (is_jmp)
            nxt = CNT_ST;
        else if (taken)
            nxt = (cur == CNT_ST) ? CNT_ST : cur + 2'd1;
        else
            nxt = (cur == CNT_SNT) ? CNT_SNT : cur - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/ysyx_23060236_bru_cnt_table.sv
// Table of 2-bit confidence counters: combinational read, one-cycle registered
// write, with the in-flight write forwarded to a same-index read.
module ysyx_23060236_bru_cnt_table
    import ysyx_23060236_bru_pkg::*;
#(
    parameter int CNT_IDX = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CNT_IDX-1:0] rd_idx,
    output cnt_t               rd_cnt,
    input  logic               wr_en,
    input  logic [CNT_IDX-1:0] wr_idx,
    input  cnt_t               wr_cnt
);

    localparam int ENTRIES = 1 << CNT_IDX;

    cnt_t               cnt_q [ENTRIES];
    logic               pend_valid;
    logic [CNT_IDX-1:0] pend_idx;
    cnt_t               pend_cnt;

    // NOTE: every entry is reset because the predictor relies on a known
    // weakly-not-taken start; a RAM-style unreset array would leave it X.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_q[i] <= CNT_WNT;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_cnt   <= CNT_WNT;
        end else begin
            pend_valid <= wr_en;
            pend_idx   <= wr_idx;
            pend_cnt   <= wr_cnt;
            if (pend_valid)
                cnt_q[pend_idx] <= pend_cnt;
        end
    end

    // The staged write has not reached the array yet, so a matching read takes it.
    always_comb begin
        rd_cnt = cnt_q[rd_idx];
        if (pend_valid && (pend_idx == rd_idx))
            rd_cnt = pend_cnt;
    end

endmodule

// File: rtl/ysyx_23060236_bru.sv
// Branch resolution unit: checks the IFU-predicted next PC, redirects IFU on a
// mispredict, trains the confidence table and emits BTB write pulses.
module ysyx_23060236_bru
    import ysyx_23060236_bru_pkg::*;
#(
    parameter int ADDR_LEN = BRU_ADDR_LEN,
    parameter int DATA_LEN = BRU_DATA_LEN,
    parameter int CNT_IDX  = 4,
    parameter int PERF_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                exu_valid,
    output logic                exu_ready,
    input  logic [ADDR_LEN-1:0] exu_pc,
    input  logic [ADDR_LEN-1:0] exu_pred_npc,
    input  logic                exu_is_br,
    input  logic                exu_is_jmp,
    input  logic                exu_taken,
    input  logic [ADDR_LEN-1:0] exu_target,
    output logic                redirect_valid,
    input  logic                redirect_ready,
    output logic [ADDR_LEN-1:0] redirect_pc,
    output logic                btb_wvalid,
    output logic [ADDR_LEN-1:0] btb_awaddr,
    output logic [DATA_LEN-1:0] btb_wdata,
    output logic [PERF_LEN-1:0] perf_br_cnt,
    output logic [PERF_LEN-1:0] perf_mis_cnt
);

    bru_state_e         state;
    logic               accept;
    logic               is_jmp;
    logic               is_br;
    logic               is_cf;
    logic               tk;
    logic               mis;
    logic [ADDR_LEN-1:0] actual;
    logic [CNT_IDX-1:0] idx;
    cnt_t               cur_cnt;
    cnt_t               new_cnt;
    logic               btb_fire;

    assign exu_ready = (state == BRU_IDLE);
    assign accept    = exu_valid & exu_ready;

    // A branch flagged as a jump too is resolved as the jump.
    assign is_jmp = exu_is_jmp;
    assign is_br  = exu_is_br & ~exu_is_jmp;
    assign is_cf  = is_br | is_jmp;

    assign tk       = is_jmp | (is_br & exu_taken);
    assign actual   = tk ? exu_target : exu_pc + ADDR_LEN'(4);
    assign mis      = (actual != exu_pred_npc);
    assign idx      = exu_pc[CNT_IDX+1:2];
    assign new_cnt  = cnt_next(cur_cnt, is_jmp, exu_taken);
    assign btb_fire = accept & tk & (new_cnt >= CNT_WT);

    ysyx_23060236_bru_cnt_table #(
        .CNT_IDX(CNT_IDX)
    ) u_cnt_table (
        .clock  (clock),
        .reset  (reset),
        .rd_idx (idx),
        .rd_cnt (cur_cnt),
        .wr_en  (accept & is_cf),
        .wr_idx (idx),
        .wr_cnt (new_cnt)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= BRU_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            btb_wvalid     <= 1'b0;
            btb_awaddr     <= '0;
            btb_wdata      <= '0;
            perf_br_cnt    <= '0;
            perf_mis_cnt   <= '0;
        end else begin
            btb_wvalid <= btb_fire;
            if (btb_fire) begin
                btb_awaddr <= exu_pc;
                btb_wdata  <= DATA_LEN'(exu_target);
            end

            case (state)
                BRU_IDLE: begin
                    if (accept && mis) begin
                        state          <= BRU_REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= actual;
                    end
                end
                BRU_REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= BRU_IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= BRU_IDLE;
                    redirect_valid <= 1'b0;
                end
            endcase

            // Perf counters stick at all-ones instead of wrapping.
            if (accept && is_cf && (perf_br_cnt != '1))
                perf_br_cnt <= perf_br_cnt + PERF_LEN'(1);
            if (accept && is_cf && mis && (perf_mis_cnt != '1))
                perf_mis_cnt <= perf_mis_cnt + PERF_LEN'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_bru.sv
// Scoreboard bench for ysyx_23060236_bru: a reference model predicts redirects,
// BTB writes and perf counts; a monitor compares whatever the DUT presents.
module tb_ysyx_23060236_bru;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        exu_valid = 1'b0;
    logic        exu_ready;
    logic [31:0] exu_pc = '0;
    logic [31:0] exu_pred_npc = '0;
    logic        exu_is_br = 1'b0;
    logic        exu_is_jmp = 1'b0;
    logic        exu_taken = 1'b0;
    logic [31:0] exu_target = '0;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [31:0] redirect_pc;
    logic        btb_wvalid;
    logic [31:0] btb_awaddr;
    logic [31:0] btb_wdata;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mis_cnt;

    ysyx_23060236_bru dut (
        .clock          (clock),
        .reset          (reset),
        .exu_valid      (exu_valid),
        .exu_ready      (exu_ready),
        .exu_pc         (exu_pc),
        .exu_pred_npc   (exu_pred_npc),
        .exu_is_br      (exu_is_br),
        .exu_is_jmp     (exu_is_jmp),
        .exu_taken      (exu_taken),
        .exu_target     (exu_target),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .btb_wvalid     (btb_wvalid),
        .btb_awaddr     (btb_awaddr),
        .btb_wdata      (btb_wdata),
        .perf_br_cnt    (perf_br_cnt),
        .perf_mis_cnt   (perf_mis_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } btb_exp_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } redir_exp_t;

    btb_exp_t   btb_q[$];
    redir_exp_t redir_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          model_cnt[16];
    logic [31:0] exp_br = '0;
    logic [31:0] exp_mis = '0;
    bit          in_redir = 0;
    logic [31:0] held_pc = '0;
    int          rv_len = 0;
    int          last_rv_len = 0;
    int          btb_seen = 0;
    bit          rr_random = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rr_random)
                redirect_ready = ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: every cycle, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (btb_wvalid) begin
                btb_seen++;
                if (btb_q.size() == 0) begin
                    check("btb_unexpected_pulse", 1, 0);
                end else begin
                    btb_exp_t e;
                    e = btb_q.pop_front();
                    check("btb_awaddr", btb_awaddr, e.addr);
                    check("btb_wdata", btb_wdata, e.data);
                    check("btb_cycle", cyc, e.cyc);
                end
            end
            if (redirect_valid) begin
                if (!in_redir) begin
                    if (redir_q.size() == 0) begin
                        check("redirect_unexpected", 1, 0);
                        held_pc = redirect_pc;
                    end else begin
                        redir_exp_t r;
                        r = redir_q.pop_front();
                        check("redirect_pc", redirect_pc, r.pc);
                        check("redirect_cycle", cyc, r.cyc);
                        held_pc = r.pc;
                    end
                    in_redir = 1;
                    rv_len = 0;
                end else begin
                    check("redirect_pc_stable", redirect_pc, held_pc);
                end
                check("ready_low_in_redirect", exu_ready, 0);
                rv_len++;
                if (redirect_ready) begin
                    in_redir = 0;
                    last_rv_len = rv_len;
                end
            end else begin
                check("ready_when_idle", exu_ready, 1);
            end
            check("perf_br_cnt", perf_br_cnt, exp_br);
            check("perf_mis_cnt", perf_mis_cnt, exp_mis);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_cnt[i] = 1;
        btb_q.delete();
        redir_q.delete();
        exp_br = '0;
        exp_mis = '0;
        in_redir = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [31:0] pc, input logic [31:0] pred, input bit br,
                         input bit jmp, input bit taken, input logic [31:0] target);
        bit          done;
        bit          cf, tk, mis;
        logic [31:0] actual;
        int          idx;
        exu_valid    = 1'b1;
        exu_pc       = pc;
        exu_pred_npc = pred;
        exu_is_br    = br;
        exu_is_jmp   = jmp;
        exu_taken    = taken;
        exu_target   = target;
        done = 0;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clock);
            if (exu_ready) begin
                cf     = br | jmp;
                tk     = jmp | (br & taken);
                actual = tk ? target : pc + 32'd4;
                mis    = (actual != pred);
                idx    = int'(pc[5:2]);
                if (cf) begin
                    if (jmp) model_cnt[idx] = 3;
                    else if (taken) model_cnt[idx] = (model_cnt[idx] == 3) ? 3 : model_cnt[idx] + 1;
                    else model_cnt[idx] = (model_cnt[idx] == 0) ? 0 : model_cnt[idx] - 1;
                end
                if (tk && model_cnt[idx] >= 2)
                    btb_q.push_back('{addr: pc, data: target, cyc: cyc + 1});
                if (mis)
                    redir_q.push_back('{pc: actual, cyc: cyc + 1});
                @(posedge clock);
                #1;
                if (cf && exp_br != 32'hffff_ffff) exp_br++;
                if (cf && mis && exp_mis != 32'hffff_ffff) exp_mis++;
                done = 1;
            end else begin
                @(posedge clock);
                #1;
            end
        end
        if (!done) check("accept_timeout", 0, 1);
        exu_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int btb_before;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_redirect_valid", redirect_valid, 0);
        check("reset_btb_wvalid", btb_wvalid, 0);
        check("reset_redirect_pc", redirect_pc, 0);
        check("reset_btb_awaddr", btb_awaddr, 0);
        check("reset_btb_wdata", btb_wdata, 0);
        check("reset_exu_ready", exu_ready, 1);
        @(posedge clock);
        #1;

        // Taken mispredict, counter 1->2, BTB write and redirect together.
        redirect_ready = 1'b1;
        issue(32'h8000_0010, 32'h8000_0014, 1, 0, 1, 32'h8000_0040);
        idle(3);

        // Redirect held for 3 cycles while a new instr waits.
        redirect_ready = 1'b0;
        issue(32'h8000_0200, 32'h8000_0300, 0, 0, 0, 32'h0);
        fork
            issue(32'h8000_0020, 32'h8000_0024, 1, 0, 0, 32'h8000_0060);
            begin
                repeat (3) @(posedge clock);
                #1;
                redirect_ready = 1'b1;
            end
        join
        check("redirect_hold_len", last_rv_len, 4);
        idle(2);

        // Jump with correct prediction.
        issue(32'h8000_0100, 32'h8000_0000, 0, 1, 1, 32'h8000_0000);
        idle(2);

        // Hysteresis: !taken, !taken, taken on one branch; no BTB writes.
        btb_before = btb_seen;
        issue(32'h8000_0030, 32'h8000_0034, 1, 0, 0, 32'h8000_0080);
        issue(32'h8000_0030, 32'h8000_0034, 1, 0, 0, 32'h8000_0080);
        issue(32'h8000_0030, 32'h8000_0080, 1, 0, 1, 32'h8000_0080);
        idle(2);
        check("hysteresis_no_btb", btb_seen - btb_before, 0);

        // Back-to-back jump then taken branch on the same index (bypass path).
        issue(32'h8000_0044, 32'h8000_0500, 0, 1, 0, 32'h8000_0500);
        issue(32'h8000_0044, 32'h8000_0600, 1, 0, 1, 32'h8000_0600);
        issue(32'h8000_0084, 32'h8000_0088, 1, 1, 0, 32'h8000_0088);
        idle(2);

        // Reset while a redirect is outstanding.
        redirect_ready = 1'b0;
        issue(32'h8000_0050, 32'h8000_0054, 0, 1, 0, 32'h8000_0700);
        check("redirect_before_reset", redirect_valid, 1);
        do_reset();
        @(negedge clock);
        check("post_reset_redirect_valid", redirect_valid, 0);
        check("post_reset_exu_ready", exu_ready, 1);
        check("post_reset_perf_br", perf_br_cnt, 0);
        check("post_reset_perf_mis", perf_mis_cnt, 0);
        @(posedge clock);
        #1;

        // Randomized traffic with random redirect back-pressure.
        rr_random = 1;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc, tgt, pred;
            int          kind, p;
            bit          br, jmp, taken;
            pc    = 32'h8000_0000 | ($urandom_range(0, 63) << 2);
            tgt   = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
            kind  = $urandom_range(0, 9);
            br    = (kind >= 4);
            jmp   = (kind == 2) || (kind == 3) || (kind == 4);
            taken = $urandom_range(0, 1);
            p     = $urandom_range(0, 3);
            if (p == 0)      pred = pc + 32'd4;
            else if (p == 1) pred = tgt;
            else if (p == 2) pred = (jmp || (br && taken)) ? tgt : pc + 32'd4;
            else             pred = $urandom;
            issue(pc, pred, br, jmp, taken, tgt);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rr_random = 0;
        redirect_ready = 1'b1;
        idle(6);
        check("btb_queue_drained", btb_q.size(), 0);
        check("redirect_queue_drained", redir_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
